mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one 64-bit memory bus between the instruction-fetch unit and the load/store unit of the multi-cycle core.
- Accepts level requests from each requester, arbitrates round-robin, and drives a single valid/ready request channel plus a response channel.
- Returns registered read data with a one-cycle finish pulse; these pulses are the ifu_finish/memu_finish inputs of the control FSM.
- Bounds response latency with a timeout that reports an error.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in WAIT_RESP before forced error completion (1..65535)
CNT_W, 16, width of timeout counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ifu_req  in  1  fetch request, level, held until ifu_finish
ifu_addr  in  64  fetch byte address
ifu_rdata  out  32  fetched instruction
ifu_finish  out  1  one-cycle completion pulse
ifu_err  out  1  valid with ifu_finish; bus error or timeout
memu_req  in  1  data request, level, held until memu_finish
memu_we  in  1  1=store, 0=load
memu_addr  in  64  data byte address
memu_wdata  in  64  store data
memu_wstrb  in  8  store byte enables
memu_rdata  out  64  load data
memu_finish  out  1  one-cycle completion pulse
memu_err  out  1  valid with memu_finish
bus_req_valid  out  1  request channel valid
bus_req_ready  in  1  request channel ready
bus_addr  out  64  {addr[63:3],3'b000}
bus_we  out  1  write enable
bus_wdata  out  64  write data
bus_wstrb  out  8  byte enables, 0 on reads
bus_resp_valid  in  1  response valid (always accepted in WAIT_RESP)
bus_resp_data  in  64  read data
bus_resp_err  in  1  response error

Behaviour:
- Reset (rst_n low, async): state=IDLE, last_grant=MEMU, counter=0; all outputs 0. Reset mid-transaction abandons it with no finish pulse.
- States:
  - IDLE: if any req, grant and latch addr/we/wdata/wstrb/owner, go ISSUE.
  - ISSUE: bus_req_valid=1 with latched fields; on bus_req_ready go WAIT_RESP, counter=0.
  - WAIT_RESP: on bus_resp_valid capture data/err, go DONE; else counter++, and at counter==TIMEOUT_CYCLES-1 go DONE with err=1 and data=0.
  - DONE: owner's finish=1 with rdata/err; all else 0. Next state IDLE.
- Arbitration:
  - Only one requester: grant it.
  - Both requesters in IDLE: grant the one not equal to last_grant.
  - last_grant updates at grant. After reset, IFU wins the first tie.
- Latency:
  - Request seen in IDLE at cycle 0 -> bus_req_valid at cycle 1.
  - Ready at cycle k -> WAIT_RESP from k+1.
  - resp_valid at cycle n -> finish at n+1.
  - Minimum latency is 3 cycles from request to finish with zero-wait bus.
- bus_req_valid is held with stable fields until ready; it never drops without handshake.
- bus_resp_valid in IDLE/ISSUE/DONE is ignored (simulation assertion flags it).
- Fetch: bus_we=0, bus_wstrb=0. ifu_rdata = addr[2] ? data[63:32] : data[31:0], selected using the latched addr.
- Load: bus_wstrb=0; memu_rdata = full 64-bit word. Byte/half extraction is done by memu.
- Store: memu_rdata=0 at finish; bus_resp_data is ignored.
- Requester drops req mid-transaction: the transaction completes and finish still pulses; the requester ignores it.
- A requester asserting req in the DONE cycle is first seen in the following IDLE cycle; there is no back-to-back grant without IDLE.
- rdata/err outputs hold their last value between finish pulses. Only the finish pulse qualifies them.

Decomposition:
- Shared package arb_pkg:
  - state enum {IDLE, ISSUE, WAIT_RESP, DONE}
  - owner enum {OWN_IFU, OWN_MEMU}
  - constants BUS_AW=64, BUS_DW=64
- One sub-module: mem_arb_rr, a 2-way round-robin grant with last_grant register and a grant-enable input.

Test Plan:
- ifu_req=1, addr=0x80000004, zero-wait bus returning 0x1111_2222_3333_4444 -> bus_addr=0x80000000, ifu_finish at cycle 3, ifu_rdata=0x11112222, ifu_err=0.
- memu store, addr=0x80001008, wdata=0xDEADBEEF, wstrb=0x0F -> bus_we=1, bus_wstrb=0x0F, memu_finish pulse, memu_rdata=0.
- Both reqs high out of reset -> IFU served first, then MEMU; on the next tie IFU wins again only after a MEMU grant (alternation).
- bus_req_ready low for 5 cycles -> bus_req_valid and fields stable all 5 cycles, then the handshake proceeds.
- TIMEOUT_CYCLES=8, no response -> finish 8 cycles after WAIT_RESP entry with err=1 and rdata=0.
- rst_n low during WAIT_RESP -> outputs 0 immediately; a later response is ignored with no finish; the next request is served normally.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and bus geometry for the instruction/data memory bus arbiter.
package arb_pkg;

    localparam int BUS_AW = 64;
    localparam int BUS_DW = 64;
    localparam int BUS_SW = BUS_DW / 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        DONE      = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IFU  = 1'b0,
        OWN_MEMU = 1'b1
    } owner_e;

    function automatic logic [BUS_AW-1:3] word_addr(input logic [BUS_AW-1:0] addr);
        return addr[BUS_AW-1:3];
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant; on a tie the requester that was not granted last wins.
module mem_arb_rr
    import arb_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   ifu_req,
    input  logic   memu_req,
    input  logic   grant_en,
    output logic   grant_valid,
    output owner_e grant_owner
);

    owner_e last_grant;

    always_comb begin
        grant_valid = grant_en && (ifu_req || memu_req);
        grant_owner = OWN_IFU;
        if (ifu_req && memu_req) begin
            grant_owner = (last_grant == OWN_IFU) ? OWN_MEMU : OWN_IFU;
        end else if (memu_req) begin
            grant_owner = OWN_MEMU;
        end
    end

    // Reset to MEMU so the first tie after reset goes to IFU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= OWN_MEMU;
        end else if (grant_valid) begin
            last_grant <= grant_owner;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one 64-bit memory bus between the fetch unit and the load/store unit,
// with registered responses, one-cycle finish pulses and a response timeout.
module mem_bus_arbiter
    import arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              ifu_req,
    input  logic [BUS_AW-1:0] ifu_addr,
    output logic [31:0]       ifu_rdata,
    output logic              ifu_finish,
    output logic              ifu_err,

    input  logic              memu_req,
    input  logic              memu_we,
    input  logic [BUS_AW-1:0] memu_addr,
    input  logic [BUS_DW-1:0] memu_wdata,
    input  logic [BUS_SW-1:0] memu_wstrb,
    output logic [BUS_DW-1:0] memu_rdata,
    output logic              memu_finish,
    output logic              memu_err,

    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [BUS_AW-1:0] bus_addr,
    output logic              bus_we,
    output logic [BUS_DW-1:0] bus_wdata,
    output logic [BUS_SW-1:0] bus_wstrb,
    input  logic              bus_resp_valid,
    input  logic [BUS_DW-1:0] bus_resp_data,
    input  logic              bus_resp_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e              state;
    state_e              state_nxt;
    owner_e              owner_q;
    owner_e              grant_owner;
    logic                grant_valid;

    logic [BUS_AW-1:3]   addr_q;
    logic                hi_q;
    logic                we_q;
    logic [BUS_DW-1:0]   wdata_q;
    logic [BUS_SW-1:0]   wstrb_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [31:0]         ifu_rdata_q;
    logic                ifu_err_q;
    logic [BUS_DW-1:0]   memu_rdata_q;
    logic                memu_err_q;

    logic                resp_take;
    logic                timeout_hit;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{ifu_addr[1:0], memu_addr[2:0]};

    mem_arb_rr u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .ifu_req     (ifu_req),
        .memu_req    (memu_req),
        .grant_en    (state == IDLE),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign resp_take   = (state == WAIT_RESP) && bus_resp_valid;
    assign timeout_hit = (state == WAIT_RESP) && !bus_resp_valid && (cnt_q == CNT_LAST);

    // FSM state (state | meaning):
    //   IDLE      | waiting for a request; arbitrate and latch the winner
    //   ISSUE     | request channel valid, waiting for bus_req_ready
    //   WAIT_RESP | waiting for bus_resp_valid, timeout counter running
    //   DONE      | finish pulse to the owner; back to IDLE next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (grant_valid) state_nxt = ISSUE;
            ISSUE:     if (bus_req_ready) state_nxt = WAIT_RESP;
            WAIT_RESP: if (resp_take || timeout_hit) state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWN_IFU;
            addr_q  <= '0;
            hi_q    <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (grant_valid) begin
            owner_q <= grant_owner;
            if (grant_owner == OWN_IFU) begin
                addr_q  <= word_addr(ifu_addr);
                hi_q    <= ifu_addr[2];
                we_q    <= 1'b0;
                wdata_q <= '0;
                wstrb_q <= '0;
            end else begin
                addr_q  <= word_addr(memu_addr);
                hi_q    <= 1'b0;
                we_q    <= memu_we;
                wdata_q <= memu_we ? memu_wdata : '0;
                wstrb_q <= memu_we ? memu_wstrb : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state == ISSUE && bus_req_ready) begin
            cnt_q <= '0;
        end else if (state == WAIT_RESP && !bus_resp_valid && !timeout_hit) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Response registers hold between finish pulses; a timeout forces data to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifu_rdata_q  <= '0;
            ifu_err_q    <= 1'b0;
            memu_rdata_q <= '0;
            memu_err_q   <= 1'b0;
        end else if (resp_take || timeout_hit) begin
            if (owner_q == OWN_IFU) begin
                if (resp_take) begin
                    ifu_rdata_q <= hi_q ? bus_resp_data[63:32] : bus_resp_data[31:0];
                end else begin
                    ifu_rdata_q <= '0;
                end
                ifu_err_q <= resp_take ? bus_resp_err : 1'b1;
            end else begin
                memu_rdata_q <= (resp_take && !we_q) ? bus_resp_data : '0;
                memu_err_q   <= resp_take ? bus_resp_err : 1'b1;
            end
        end
    end

    assign bus_req_valid = (state == ISSUE);
    assign bus_addr      = bus_req_valid ? {addr_q, 3'b000} : '0;
    assign bus_we        = bus_req_valid && we_q;
    assign bus_wdata     = bus_req_valid ? wdata_q : '0;
    assign bus_wstrb     = bus_req_valid ? wstrb_q : '0;

    assign ifu_finish  = (state == DONE) && (owner_q == OWN_IFU);
    assign memu_finish = (state == DONE) && (owner_q == OWN_MEMU);
    assign ifu_rdata   = ifu_rdata_q;
    assign ifu_err     = ifu_err_q;
    assign memu_rdata  = memu_rdata_q;
    assign memu_err    = memu_err_q;

    resp_outside_wait: assert property (@(posedge clk) disable iff (!rst_n)
        bus_resp_valid |-> (state == WAIT_RESP))
        else $warning("bus_resp_valid ignored outside WAIT_RESP");

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: latency, round-robin, stall, timeout, reset abort.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req;
    logic [63:0] ifu_addr;
    logic [31:0] ifu_rdata;
    logic        ifu_finish;
    logic        ifu_err;
    logic        memu_req;
    logic        memu_we;
    logic [63:0] memu_addr;
    logic [63:0] memu_wdata;
    logic [7:0]  memu_wstrb;
    logic [63:0] memu_rdata;
    logic        memu_finish;
    logic        memu_err;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [63:0] bus_addr;
    logic        bus_we;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wstrb;
    logic        bus_resp_valid;
    logic [63:0] bus_resp_data;
    logic        bus_resp_err;

    int total = 0;
    int bad   = 0;

    logic        o_valid;
    logic [63:0] o_addr;
    logic        o_we;
    logic [7:0]  o_wstrb;
    logic [63:0] o_wdata;
    logic        o_ifu_fin;
    logic        o_memu_fin;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ifu_req        (ifu_req),
        .ifu_addr       (ifu_addr),
        .ifu_rdata      (ifu_rdata),
        .ifu_finish     (ifu_finish),
        .ifu_err        (ifu_err),
        .memu_req       (memu_req),
        .memu_we        (memu_we),
        .memu_addr      (memu_addr),
        .memu_wdata     (memu_wdata),
        .memu_wstrb     (memu_wstrb),
        .memu_rdata     (memu_rdata),
        .memu_finish    (memu_finish),
        .memu_err       (memu_err),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_addr       (bus_addr),
        .bus_we         (bus_we),
        .bus_wdata      (bus_wdata),
        .bus_wstrb      (bus_wstrb),
        .bus_resp_valid (bus_resp_valid),
        .bus_resp_data  (bus_resp_data),
        .bus_resp_err   (bus_resp_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        ifu_req        = 1'b0;
        ifu_addr       = '0;
        memu_req       = 1'b0;
        memu_we        = 1'b0;
        memu_addr      = '0;
        memu_wdata     = '0;
        memu_wstrb     = '0;
        bus_req_ready  = 1'b1;
        bus_resp_valid = 1'b0;
        bus_resp_data  = '0;
        bus_resp_err   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Zero-wait transaction starting in an IDLE cycle where a request is visible.
    task automatic txn(input logic [63:0] d, input logic e);
        tick();
        o_valid = bus_req_valid;
        o_addr  = bus_addr;
        o_we    = bus_we;
        o_wstrb = bus_wstrb;
        o_wdata = bus_wdata;
        tick();
        bus_resp_valid = 1'b1;
        bus_resp_data  = d;
        bus_resp_err   = e;
        tick();
        bus_resp_valid = 1'b0;
        bus_resp_data  = '0;
        bus_resp_err   = 1'b0;
        o_ifu_fin  = ifu_finish;
        o_memu_fin = memu_finish;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_valid", bus_req_valid, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_ifu_fin", ifu_finish, 0);
        chk("rst_memu_fin", memu_finish, 0);
        chk("rst_ifu_rdata", ifu_rdata, 0);

        // Fetch from the upper word of a doubleword.
        ifu_req  = 1'b1;
        ifu_addr = 64'h8000_0004;
        txn(64'h1111_2222_3333_4444, 1'b0);
        chk("f_valid", o_valid, 1);
        chk("f_addr", o_addr, 64'h8000_0000);
        chk("f_we", o_we, 0);
        chk("f_wstrb", o_wstrb, 0);
        chk("f_fin", o_ifu_fin, 1);
        chk("f_mfin", o_memu_fin, 0);
        chk("f_rdata", ifu_rdata, 32'h1111_2222);
        chk("f_err", ifu_err, 0);
        ifu_req = 1'b0;
        tick();
        chk("f_fin_drop", ifu_finish, 0);
        chk("f_rdata_hold", ifu_rdata, 32'h1111_2222);

        // Store: response data must not reach memu_rdata.
        memu_req   = 1'b1;
        memu_we    = 1'b1;
        memu_addr  = 64'h8000_1008;
        memu_wdata = 64'hDEAD_BEEF;
        memu_wstrb = 8'h0F;
        txn(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        chk("s_we", o_we, 1);
        chk("s_wstrb", o_wstrb, 8'h0F);
        chk("s_wdata", o_wdata, 64'hDEAD_BEEF);
        chk("s_addr", o_addr, 64'h8000_1008);
        chk("s_fin", o_memu_fin, 1);
        chk("s_ifin", o_ifu_fin, 0);
        chk("s_rdata", memu_rdata, 0);
        chk("s_err", memu_err, 0);
        memu_req = 1'b0;
        memu_we  = 1'b0;
        tick();

        // Ties out of reset: IFU, MEMU, IFU.
        do_reset();
        ifu_req    = 1'b1;
        ifu_addr   = 64'h8000_0100;
        memu_req   = 1'b1;
        memu_we    = 1'b0;
        memu_addr  = 64'h8000_2010;
        memu_wstrb = 8'hFF;
        txn(64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
        chk("t1_ifin", o_ifu_fin, 1);
        chk("t1_addr", o_addr, 64'h8000_0100);
        chk("t1_rdata", ifu_rdata, 32'hCCCC_DDDD);
        tick();
        txn(64'h0123_4567_89AB_CDEF, 1'b0);
        chk("t2_mfin", o_memu_fin, 1);
        chk("t2_addr", o_addr, 64'h8000_2010);
        chk("t2_we", o_we, 0);
        chk("t2_wstrb", o_wstrb, 0);
        chk("t2_rdata", memu_rdata, 64'h0123_4567_89AB_CDEF);
        tick();
        txn(64'h0, 1'b1);
        chk("t3_ifin", o_ifu_fin, 1);
        chk("t3_mfin", o_memu_fin, 0);
        chk("t3_err", ifu_err, 1);
        ifu_req  = 1'b0;
        memu_req = 1'b0;
        tick();

        // Request channel stall: fields stay latched while ready is low.
        bus_req_ready = 1'b0;
        ifu_req  = 1'b1;
        ifu_addr = 64'h8000_000C;
        tick();
        ifu_addr = 64'h1234_5678_9ABC_DEF0;
        for (int i = 0; i < 5; i++) begin
            chk("st_valid", bus_req_valid, 1);
            chk("st_addr", bus_addr, 64'h8000_0008);
            tick();
        end
        chk("st_valid6", bus_req_valid, 1);
        bus_req_ready = 1'b1;
        tick();
        chk("st_wait", bus_req_valid, 0);
        bus_resp_valid = 1'b1;
        bus_resp_data  = 64'h5A5A_0001_A5A5_0002;
        tick();
        bus_resp_valid = 1'b0;
        chk("st_fin", ifu_finish, 1);
        chk("st_rdata", ifu_rdata, 32'h5A5A_0001);
        chk("st_err", ifu_err, 0);
        ifu_req = 1'b0;
        tick();

        // Timeout with TIMEOUT_CYCLES=8: finish 8 cycles after WAIT_RESP entry.
        ifu_req  = 1'b1;
        ifu_addr = 64'h8000_0004;
        tick();
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to_nofin", ifu_finish, 0);
        end
        tick();
        chk("to_fin", ifu_finish, 1);
        chk("to_err", ifu_err, 1);
        chk("to_rdata", ifu_rdata, 0);
        ifu_req = 1'b0;
        tick();
        chk("to_fin_drop", ifu_finish, 0);

        // Reset during WAIT_RESP abandons the load.
        memu_req  = 1'b1;
        memu_we   = 1'b0;
        memu_addr = 64'h8000_3000;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ra_mrdata", memu_rdata, 0);
        chk("ra_ierr", ifu_err, 0);
        chk("ra_valid", bus_req_valid, 0);
        chk("ra_mfin", memu_finish, 0);
        memu_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        bus_resp_valid = 1'b1;
        bus_resp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        bus_resp_valid = 1'b0;
        chk("ra_late_mfin", memu_finish, 0);
        chk("ra_late_ifin", ifu_finish, 0);
        chk("ra_late_rdata", memu_rdata, 0);
        tick();
        chk("ra_late_mfin2", memu_finish, 0);
        memu_req = 1'b1;
        txn(64'h5555_6666_7777_8888, 1'b0);
        chk("ra_next_mfin", o_memu_fin, 1);
        chk("ra_next_addr", o_addr, 64'h8000_3000);
        chk("ra_next_rdata", memu_rdata, 64'h5555_6666_7777_8888);
        memu_req = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
